spike_det: RTL and testbench
============================

SPIKE_DET -- requirements
Module: spike_det

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 6; log2 of threshold-estimation window length in samples (range 2..10).
REQ-002 SHALL have parameter K, default 8; unsigned integer threshold multiplier (range 1..15).
REQ-003 SHALL have parameter REFRACT, default 32; refractory length in samples (range 1..1023).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port p  input  12  signed Q2.10 energy sample from the upstream operator stage; one new sample every clk.
REQ-007 SHALL have port spike  output  1  registered one-cycle detection pulse.
REQ-008 SHALL have port thr  output  15  unsigned current detection threshold, same LSB weight as p.
REQ-009 SHALL have port calib  output  1  high while the first window is being collected; detection disabled.
REQ-010 SHALL have port spk_cnt  output  16  unsigned count of spike pulses since reset.

Function
REQ-011 SHALL clamp each sample to pc = max(p, 0), an 11-bit unsigned value, before accumulation.
REQ-012 SHALL accumulate pc every cycle, including in REFRACT, into an unsigned (11+WIN_LOG2)-bit accumulator with no overflow.
REQ-013 SHALL keep a WIN_LOG2-bit sample index that increments every cycle and wraps from 2^WIN_LOG2-1 to 0.
REQ-014 SHALL, on the last sample of a window (index = 2^WIN_LOG2-1), load thr <= K * ((acc + pc) >> WIN_LOG2) (truncating shift) and clear acc to 0.
REQ-015 SHALL hold thr constant between window ends.
REQ-016 SHALL implement FSM states CALIB, ARMED and REFRACT.
REQ-017 SHALL move CALIB -> ARMED on the clk edge that completes the first window; calib deasserts on that same edge.
REQ-018 SHALL, in ARMED, detect when signed p > signed {0, thr}; the comparison is strict.
REQ-019 SHALL, on detection, assert spike for exactly the next cycle, increment spk_cnt (wrapping 0xFFFF -> 0) and enter REFRACT.
REQ-020 SHALL, in REFRACT, ignore exactly REFRACT samples; the first sample eligible for detection arrives REFRACT+1 cycles after the detecting sample.
REQ-021 SHALL give detection latency of 1 cycle: sample at edge t produces spike high during cycle t+1.
REQ-022 SHALL, when a detection and a window-end update fall on the same sample, compare against the pre-update thr; the new thr applies from the next sample.
REQ-023 SHALL never assert spike in CALIB, whatever the value of p.
REQ-024 SHALL continue threshold updates in every state after CALIB.

Reset
REQ-025 SHALL, on rst high at a clk edge, set state=CALIB, acc=0, sample index=0, refractory counter=0, spike=0, thr=0, calib=1, spk_cnt=0.
REQ-026 SHALL give rst priority over all other events, including a detection or window end on the same edge.
REQ-027 SHALL, after a reset mid-operation, redo the full calibration window before any detection.

Verification (defaults WIN_LOG2=6, K=8, REFRACT=32)
REQ-028 SHALL check: reset, then p=100 for 64 cycles -> calib=1 throughout; thr=800 and calib=0 after the 64th edge; spike never asserted.
REQ-029 SHALL check: armed with thr=800, p=800 -> no spike; then p=801 -> spike high for one cycle after, spk_cnt=1.
REQ-030 SHALL check: armed with thr=800, p=2047 held for 40 samples starting at window index 0 -> spikes in the cycles after sample 0 and sample 33 only; spk_cnt=2.
REQ-031 SHALL check: calibration with p=-500 constant -> thr=0; then p=1 -> spike; then p=0 (after REFRACT) -> no spike.
REQ-032 SHALL check: with thr=800, window-index-63 sample p=900 while the window mean gives a new thr of 8000 -> spike asserted; then p=900 on the next eligible sample -> no spike.
REQ-033 SHALL check: rst asserted during REFRACT -> next cycle spike=0, thr=0, calib=1, spk_cnt=0; p=2047 during the following 64 samples -> no spike.

Source files
------------

// File: rtl/spike_det.sv
// Adaptive-threshold spike detector: the threshold is K times the mean clamped energy
// of the previous window, and each detection is followed by a refractory dead time.
module spike_det #(
    parameter int WIN_LOG2 = 6,
    parameter int K        = 8,
    parameter int REFRACT  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [11:0] p,
    output logic               spike,
    output logic [14:0]        thr,
    output logic               calib,
    output logic [15:0]        spk_cnt
);

    localparam int ACC_W = 11 + WIN_LOG2;
    localparam logic [9:0] REFR_INIT = 10'(REFRACT - 1);

    typedef enum logic [1:0] {
        CALIB,
        ARMED,
        REFR
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [WIN_LOG2-1:0] idx_q, idx_d;
    logic [9:0]          rcnt_q, rcnt_d;
    logic                spike_q, spike_d;
    logic [14:0]         thr_q, thr_d;
    logic                calib_q, calib_d;
    logic [15:0]         cnt_q, cnt_d;

    logic [10:0]         pc;
    logic [ACC_W-1:0]    acc_sum;
    logic [14:0]         thr_new;
    logic                win_end;
    logic                detect;

    // Negative energy is meaningless for the estimate, so it contributes zero.
    assign pc      = p[11] ? 11'd0 : p[10:0];
    assign acc_sum = acc_q + ACC_W'(pc);
    assign thr_new = 15'(32'(K) * 32'(acc_sum >> WIN_LOG2));
    assign win_end = (idx_q == {WIN_LOG2{1'b1}});
    assign detect  = (state_q == ARMED) &&
                     ($signed({{4{p[11]}}, p}) > $signed({1'b0, thr_q}));

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        calib_d = calib_q;
        idx_d   = idx_q + 1'b1;
        acc_d   = win_end ? '0 : acc_sum;
        thr_d   = win_end ? thr_new : thr_q;
        spike_d = detect;
        cnt_d   = detect ? cnt_q + 16'd1 : cnt_q;

        case (state_q)
            CALIB: begin
                if (win_end) begin
                    state_d = ARMED;
                    calib_d = 1'b0;
                end
            end
            ARMED: begin
                if (detect) begin
                    state_d = REFR;
                    rcnt_d  = REFR_INIT;
                end
            end
            REFR: begin
                if (rcnt_q == 10'd0) begin
                    state_d = ARMED;
                end else begin
                    rcnt_d = rcnt_q - 10'd1;
                end
            end
            default: begin
                state_d = CALIB;
                calib_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CALIB;
            acc_q   <= '0;
            idx_q   <= '0;
            rcnt_q  <= '0;
            spike_q <= 1'b0;
            thr_q   <= '0;
            calib_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            rcnt_q  <= rcnt_d;
            spike_q <= spike_d;
            thr_q   <= thr_d;
            calib_q <= calib_d;
            cnt_q   <= cnt_d;
        end
    end

    assign spike   = spike_q;
    assign thr     = thr_q;
    assign calib   = calib_q;
    assign spk_cnt = cnt_q;

endmodule

// File: tb/tb_spike_det.sv
// Self-checking bench for spike_det: expectations are queued as stimulus is driven
// and popped once the DUT has registered its response one edge later.
module tb_spike_det;

    localparam int WIN_LOG2 = 6;
    localparam int K        = 8;
    localparam int REFRACT  = 32;
    localparam int WIN      = 1 << WIN_LOG2;

    typedef struct {
        logic               rst;
        logic signed [11:0] p;
        logic               exp_spike;
        logic [14:0]        exp_thr;
        logic               exp_calib;
        logic [15:0]        exp_cnt;
        string              name;
    } vec_t;

    logic               clk;
    logic               rst;
    logic signed [11:0] p;
    logic               spike;
    logic [14:0]        thr;
    logic               calib;
    logic [15:0]        spk_cnt;

    vec_t exp_q[$];
    int   n_checks;
    int   n_pass;

    spike_det #(
        .WIN_LOG2(WIN_LOG2),
        .K       (K),
        .REFRACT (REFRACT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .p      (p),
        .spike  (spike),
        .thr    (thr),
        .calib  (calib),
        .spk_cnt(spk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string field, input int act, input int req);
        n_checks++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s.%s: got %0d, required %0d (t=%0t)", nm, field, act, req, $time);
        end
    endtask

    task automatic checkOutput();
        vec_t v;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL scoreboard: got empty queue, required a pending expectation");
        end else begin
            v = exp_q.pop_front();
            cmp(v.name, "spike",   int'(spike),   int'(v.exp_spike));
            cmp(v.name, "thr",     int'(thr),     int'(v.exp_thr));
            cmp(v.name, "calib",   int'(calib),   int'(v.exp_calib));
            cmp(v.name, "spk_cnt", int'(spk_cnt), int'(v.exp_cnt));
        end
    endtask

    task automatic applyStimulus(input logic r, input int pv, input logic es, input int et,
                                 input logic ec, input int en, input string nm);
        vec_t v;
        v.rst       = r;
        v.p         = 12'(pv);
        v.exp_spike = es;
        v.exp_thr   = 15'(et);
        v.exp_calib = ec;
        v.exp_cnt   = 16'(en);
        v.name      = nm;
        exp_q.push_back(v);
        rst = v.rst;
        p   = v.p;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Reset, then one full window of constant input; thr appears on the final edge.
    task automatic calibrate(input int val, input string nm);
        int thr_exp;
        thr_exp = K * ((val > 0) ? val : 0);
        applyStimulus(1'b1, val, 1'b0, 0, 1'b1, 0, {nm, "_rst"});
        for (int i = 0; i < WIN; i++) begin
            applyStimulus(1'b0, val, 1'b0, (i == WIN - 1) ? thr_exp : 0,
                          (i != WIN - 1), 0, nm);
        end
    endtask

    initial begin
        vec_t tbl[4];
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        p        = '0;
        repeat (2) @(posedge clk);
        #1;

        // Constant 100 for a window: calib high throughout, thr = 800 at the end.
        calibrate(100, "calib100");

        // Strict comparison at the threshold, then a single pulse and refractory ignore.
        tbl[0] = '{1'b0, 12'sd800,  1'b0, 15'd800, 1'b0, 16'd0, "p800_no_spike"};
        tbl[1] = '{1'b0, 12'sd801,  1'b1, 15'd800, 1'b0, 16'd1, "p801_spike"};
        tbl[2] = '{1'b0, 12'sd801,  1'b0, 15'd800, 1'b0, 16'd1, "refr_801"};
        tbl[3] = '{1'b0, 12'sd2047, 1'b0, 15'd800, 1'b0, 16'd1, "refr_2047"};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(tbl[i].rst, int'(tbl[i].p), tbl[i].exp_spike, int'(tbl[i].exp_thr),
                          tbl[i].exp_calib, int'(tbl[i].exp_cnt), tbl[i].name);
        end

        // Held maximum input: spikes after sample 0 and sample REFRACT+1 only.
        calibrate(100, "calib100b");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 2047, (i == 0 || i == REFRACT + 1), 800, 1'b0,
                          (i >= REFRACT + 1) ? 2 : 1, "hold2047");
        end

        // All-negative calibration gives thr = 0; any positive sample then fires.
        calibrate(-500, "calib_neg");
        applyStimulus(1'b0, 1, 1'b1, 0, 1'b0, 1, "p1_spike");
        for (int i = 0; i < REFRACT; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1, "refr_zero");
        end
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1, "eligible_p0");

        // Detection on the window-end sample uses the old thr; the new thr (8000) applies after.
        calibrate(100, "calib100c");
        applyStimulus(1'b0, 1000, 1'b1, 800, 1'b0, 1, "win_start_spike");
        for (int i = 0; i < REFRACT; i++) begin
            applyStimulus(1'b0, (i == REFRACT - 1) ? 1210 : 1190, 1'b0, 800, 1'b0, 1, "refr_fill");
        end
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 800, 1'b0, 800, 1'b0, 1, "armed_fill");
        end
        applyStimulus(1'b0, 900, 1'b1, 8000, 1'b0, 2, "win_end_spike");
        for (int i = 0; i < REFRACT; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 8000, 1'b0, 2, "refr_after_update");
        end
        applyStimulus(1'b0, 900, 1'b0, 8000, 1'b0, 2, "p900_vs_new_thr");

        // Reset during refractory clears everything and forces a fresh calibration.
        calibrate(100, "calib100d");
        applyStimulus(1'b0, 2047, 1'b1, 800, 1'b0, 1, "pre_rst_spike");
        applyStimulus(1'b0, 2047, 1'b0, 800, 1'b0, 1, "pre_rst_refr");
        calibrate(2047, "rst_in_refr");
        applyStimulus(1'b0, 2047, 1'b0, K * 2047, 1'b0, 0, "below_new_thr");

        // Reset wins over a detection on the same edge.
        calibrate(100, "calib100e");
        applyStimulus(1'b1, 2047, 1'b0, 0, 1'b1, 0, "rst_vs_detect");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
